// File: rtl/nabp.sv
// rtl/nabp.sv - nearest-bin CT back-projection engine (optional macro: NABP_SKIP_OUTSIDE_EN)
// The trig ROM is built in as a constant table for A=16 angles in Q2.10.
module nabp #(
  parameter  int DATA_W  = 8,
  parameter  int LOG_N   = 4,
  parameter  int LOG_A   = 4,
  parameter  int LOG_P   = 5,
  parameter  int FRAC    = 10,
  localparam int IA_W    = 2 * LOG_N,
  localparam int SA_W    = LOG_A + LOG_P,
  localparam int CACHE_W = DATA_W + LOG_A
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sg_kick,
  input  logic [DATA_W-1:0]  sg_val,
  input  logic               ir_enable,
  output logic               sg_done,
  output logic [SA_W-1:0]    sg_addr,
  output logic               ir_kick,
  output logic               ir_done,
  output logic               ir_addr_valid,
  output logic [IA_W-1:0]    ir_addr,
  output logic [CACHE_W-1:0] ir_val
);
  localparam int A   = 1 << LOG_A;
  localparam int P   = 1 << LOG_P;
  localparam int T_W = 20;

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t              state_q;
  logic [IA_W-1:0]     pixel_q;
  logic [LOG_A-1:0]    angle_q;
  logic [CACHE_W-1:0]  acc_q;
  logic [SA_W-1:0]     sg_addr_q;
  logic                inr_q;      // address now on sg_addr is inside the detector
  logic                inr_d1_q;   // same flag, aligned with sg_val
  logic                sg_done_q;
  logic                ir_kick_q;
  logic                ir_done_q;
  logic                valid_q;

  logic [IA_W-1:0]        calc_pixel;
  logic [LOG_A-1:0]       calc_angle;
  logic [LOG_N-1:0]       cx, cy;
  logic signed [LOG_N:0]  xc, yc;
  logic signed [11:0]     cos_v, sin_v;
  logic signed [T_W-1:0]  t, r, s;
  int                     ang_k, sin_k;
  logic [SA_W-1:0]        addr_d;
  logic                   inr_d;
  logic                   skip_d;

  // cos(k*pi/A) in Q2.10 for k=0..A-1, folded around pi/2
  function automatic logic signed [11:0] rom_cos(input int k);
    int m;
    logic signed [11:0] mag;
    m = (k <= A / 2) ? k : A - k;
    case (m)
      0:       mag = 12'sd1024;
      1:       mag = 12'sd1004;
      2:       mag = 12'sd946;
      3:       mag = 12'sd851;
      4:       mag = 12'sd724;
      5:       mag = 12'sd569;
      6:       mag = 12'sd392;
      7:       mag = 12'sd200;
      default: mag = 12'sd0;
    endcase
    rom_cos = (k > A / 2) ? -mag : mag;
  endfunction

  // Next sinogram address: for the upcoming angle of this pixel, or angle 0 of the next pixel
  always_comb begin
    calc_pixel = pixel_q;
    calc_angle = angle_q + LOG_A'(1);
    case (state_q)
      S_IDLE:  begin calc_pixel = '0;                calc_angle = '0; end
      S_WRITE: begin calc_pixel = pixel_q + IA_W'(1); calc_angle = '0; end
      default: ;
    endcase
    cx = calc_pixel[LOG_N-1:0];
    cy = calc_pixel[IA_W-1:LOG_N];
    // x - N/2 as a signed value: invert the MSB and sign-extend it
    xc = {~cx[LOG_N-1], ~cx[LOG_N-1], cx[LOG_N-2:0]};
    yc = {~cy[LOG_N-1], ~cy[LOG_N-1], cy[LOG_N-2:0]};
    ang_k = int'(calc_angle);
    sin_k = (ang_k <= A / 2) ? (A / 2 - ang_k) : (ang_k - A / 2);
    cos_v = rom_cos(ang_k);
    sin_v = rom_cos(sin_k);
    t = T_W'(xc) * T_W'(cos_v) + T_W'(yc) * T_W'(sin_v);
    r = (t + T_W'(1 << (FRAC - 1))) >>> FRAC;
    s = r + T_W'(P / 2);
    addr_d = {calc_angle, s[LOG_P-1:0]};
    inr_d  = ~s[T_W-1] && (s[T_W-2:LOG_P] == '0);
    skip_d = 1'b0;
`ifdef NABP_SKIP_OUTSIDE_EN
    skip_d = (((2*LOG_N+3)'(xc) * (2*LOG_N+3)'(xc)) + ((2*LOG_N+3)'(yc) * (2*LOG_N+3)'(yc)))
             > (2*LOG_N+3)'((1 << (2*LOG_N)) / 4);
`endif
  end

  // Control FSM: accumulate A samples per pixel, drain, then hand the pixel to the image RAM
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q   <= S_IDLE;
      pixel_q   <= '0;
      angle_q   <= '0;
      acc_q     <= '0;
      sg_addr_q <= '0;
      inr_q     <= 1'b0;
      inr_d1_q  <= 1'b0;
      sg_done_q <= 1'b0;
      ir_kick_q <= 1'b0;
      ir_done_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      sg_done_q <= 1'b0;
      ir_kick_q <= 1'b0;
      ir_done_q <= 1'b0;
      inr_d1_q  <= inr_q;
      case (state_q)
        S_IDLE: begin
          if (sg_kick) begin
            ir_kick_q <= 1'b1;
            pixel_q   <= calc_pixel;
            angle_q   <= '0;
            if (skip_d) begin
              state_q   <= S_WRITE;
              acc_q     <= '0;
              valid_q   <= 1'b1;
              sg_done_q <= (calc_pixel == '1);
            end else begin
              state_q   <= S_ACCUM;
              sg_addr_q <= addr_d;
              inr_q     <= inr_d;
            end
          end
        end
        S_ACCUM: begin
          if (angle_q == '0)
            acc_q <= '0;
          else if (inr_d1_q)
            acc_q <= acc_q + CACHE_W'(sg_val);
          if (angle_q == LOG_A'(A - 1)) begin
            state_q   <= S_DRAIN;
            sg_done_q <= (pixel_q == '1);
          end else begin
            angle_q   <= calc_angle;
            sg_addr_q <= addr_d;
            inr_q     <= inr_d;
          end
        end
        S_DRAIN: begin
          if (inr_d1_q)
            acc_q <= acc_q + CACHE_W'(sg_val);
          state_q <= S_WRITE;
          valid_q <= 1'b1;
        end
        S_WRITE: begin
          if (ir_enable) begin
            valid_q <= 1'b0;
            if (pixel_q == '1) begin
              state_q   <= S_DONE;
              ir_done_q <= 1'b1;
            end else begin
              pixel_q <= calc_pixel;
              angle_q <= '0;
              if (skip_d) begin
                acc_q     <= '0;
                valid_q   <= 1'b1;
                sg_done_q <= (calc_pixel == '1);
              end else begin
                state_q   <= S_ACCUM;
                sg_addr_q <= addr_d;
                inr_q     <= inr_d;
              end
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sg_done       = sg_done_q;
  assign sg_addr       = sg_addr_q;
  assign ir_kick       = ir_kick_q;
  assign ir_done       = ir_done_q;
  assign ir_addr_valid = valid_q;
  assign ir_addr       = pixel_q;
  assign ir_val        = acc_q;
endmodule

// File: tb/tb_nabp.sv
// tb/tb_nabp.sv - randomized self-checking bench for nabp against a real-arithmetic model
module tb_nabp;
  localparam int N = 16, A = 16, P = 32, NPIX = 256;
  localparam real PI = 3.14159265358979;

  logic        clk = 1'b0, reset_n = 1'b1, sg_kick = 1'b0, ir_enable = 1'b0;
  logic [7:0]  sg_val;
  logic        sg_done, ir_kick, ir_done, ir_addr_valid;
  logic [8:0]  sg_addr;
  logic [7:0]  ir_addr;
  logic [11:0] ir_val;

  nabp dut (
    .clk(clk), .reset_n(reset_n), .sg_kick(sg_kick), .sg_val(sg_val), .ir_enable(ir_enable),
    .sg_done(sg_done), .sg_addr(sg_addr), .ir_kick(ir_kick), .ir_done(ir_done),
    .ir_addr_valid(ir_addr_valid), .ir_addr(ir_addr), .ir_val(ir_val)
  );

  always #5 clk = ~clk;

  int sino [512];
  int exp_img [NPIX];
  int total = 0, bad = 0;

  // external sinogram LUT with one-cycle read latency
  always @(posedge clk) sg_val <= 8'(sino[sg_addr]);

  int cyc = 0;
  always @(posedge clk) cyc++;

  int wr_addr_q[$], wr_val_q[$], wr_cyc_q[$];
  int kick_n, done_n, sgd_n, kick_cyc, done_cyc, sgd_cyc, stall_err;
  logic [8:0]  first_wr_sg_addr;
  logic        stalled_q = 1'b0;
  logic [7:0]  last_addr;
  logic [11:0] last_val;

  // observe the DUT mid-cycle
  always @(negedge clk) begin
    if (stalled_q && (!ir_addr_valid || ir_addr !== last_addr || ir_val !== last_val)) stall_err++;
    stalled_q = ir_addr_valid && !ir_enable;
    last_addr = ir_addr;
    last_val  = ir_val;
    if (ir_addr_valid && ir_enable) begin
      if (wr_addr_q.size() == 0) first_wr_sg_addr = sg_addr;
      wr_addr_q.push_back(int'(ir_addr));
      wr_val_q.push_back(int'(ir_val));
      wr_cyc_q.push_back(cyc);
    end
    if (ir_kick) begin kick_n++; kick_cyc = cyc; end
    if (ir_done) begin done_n++; done_cyc = cyc; end
    if (sg_done) begin sgd_n++;  sgd_cyc  = cyc; end
  end

  function automatic int rom(input real v);
    return $rtoi($floor(v * 1024.0 + 0.5));
  endfunction

  // each pixel = sum over angles of the nearest in-range bin of its projection
  function automatic void build_model();
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++) begin
        int acc, xc, yc;
        acc = 0; xc = x - N / 2; yc = y - N / 2;
        for (int a = 0; a < A; a++) begin
          int c, s, t, b;
          c = rom($cos(real'(a) * PI / A));
          s = rom($sin(real'(a) * PI / A));
          t = xc * c + yc * s;
          b = $rtoi($floor(real'(t) / 1024.0 + 0.5)) + P / 2;
          if (b >= 0 && b < P) acc += sino[a * P + b];
        end
`ifdef NABP_SKIP_OUTSIDE_EN
        if (xc * xc + yc * yc > (N / 2) * (N / 2)) acc = 0;
`endif
        exp_img[y * N + x] = acc;
      end
  endfunction

  logic [8:0] sg_addr_at_kick;

  task automatic run_image(input bit toggle, input bit rekick);
    wr_addr_q.delete(); wr_val_q.delete(); wr_cyc_q.delete();
    kick_n = 0; done_n = 0; sgd_n = 0; stall_err = 0;
    kick_cyc = -1; done_cyc = -1; sgd_cyc = -1;
    @(posedge clk); #1;
    sg_addr_at_kick = sg_addr;
    sg_kick = 1'b1;
    ir_enable = !toggle;
    for (int i = 0; i < 20000 && done_n == 0; i++) begin
      @(posedge clk); #1;
      sg_kick = rekick && (i % 500 == 50);
      ir_enable = toggle ? ((i / 3) % 2 == 1) : 1'b1;
    end
    sg_kick = 1'b0;
    ir_enable = 1'b1;
    total++;
    if (done_n == 0) begin bad++; $display("FAIL run_timeout ir_done count=0 required>=1"); end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (ir_addr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ir_addr_valid); end
    total++; if (sg_addr !== 9'd0)       begin bad++; $display("FAIL reset_sg_addr got=%0d want=0", sg_addr); end
    total++; if (ir_val !== 12'd0)       begin bad++; $display("FAIL reset_ir_val got=%0d want=0", ir_val); end
    total++; if ({sg_done, ir_kick, ir_done} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b want=000", {sg_done, ir_kick, ir_done}); end
    total++; if (ir_addr !== 8'd0)       begin bad++; $display("FAIL reset_ir_addr got=%0d want=0", ir_addr); end
    @(posedge clk); #1;
    reset_n = 1'b0;
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < 512; i++) sino[i] = 1;
    build_model();
    run_image(1'b0, 1'b0);
    total++; if (wr_addr_q.size() != NPIX) begin bad++; $display("FAIL ones_count got=%0d want=%0d", wr_addr_q.size(), NPIX); end
    for (int k = 0; k < wr_addr_q.size() && k < NPIX; k++) begin
      total++; if (wr_addr_q[k] != k) begin bad++; $display("FAIL ones_addr idx=%0d got=%0d want=%0d", k, wr_addr_q[k], k); end
      total++; if (wr_val_q[k] != exp_img[k]) begin bad++; $display("FAIL ones_val idx=%0d got=%0d want=%0d", k, wr_val_q[k], exp_img[k]); end
    end
    if (wr_cyc_q.size() == NPIX) begin
      total++; if (done_cyc != wr_cyc_q[NPIX-1] + 1) begin bad++; $display("FAIL ones_done_lat got=%0d want=%0d", done_cyc, wr_cyc_q[NPIX-1] + 1); end
      total++; if (!(sgd_n == 1 && sgd_cyc < done_cyc)) begin bad++; $display("FAIL ones_sg_done n=%0d cyc=%0d want one pulse before %0d", sgd_n, sgd_cyc, done_cyc); end
`ifdef NABP_SKIP_OUTSIDE_EN
      total++; if (wr_val_q[0] != 0) begin bad++; $display("FAIL skip_corner got=%0d want=0", wr_val_q[0]); end
      total++; if (first_wr_sg_addr !== sg_addr_at_kick) begin bad++; $display("FAIL skip_sg_addr got=%0d want=%0d", first_wr_sg_addr, sg_addr_at_kick); end
      total++; if (wr_val_q[8 * N + 8] != 16) begin bad++; $display("FAIL skip_centre got=%0d want=16", wr_val_q[8 * N + 8]); end
`else
      total++; if (wr_val_q[0] != 16) begin bad++; $display("FAIL ones_corner got=%0d want=16", wr_val_q[0]); end
      total++; if (wr_cyc_q[0] - kick_cyc != A + 1) begin bad++; $display("FAIL ones_first_lat got=%0d want=%0d", wr_cyc_q[0] - kick_cyc, A + 1); end
      total++; if (wr_cyc_q[NPIX-1] - kick_cyc + 1 != NPIX * (A + 2)) begin bad++; $display("FAIL ones_run_len got=%0d want=%0d", wr_cyc_q[NPIX-1] - kick_cyc + 1, NPIX * (A + 2)); end
      total++; if (sgd_cyc != wr_cyc_q[NPIX-1] - 1) begin bad++; $display("FAIL ones_sg_done_cyc got=%0d want=%0d", sgd_cyc, wr_cyc_q[NPIX-1] - 1); end
`endif
    end
  endtask

  task automatic test_delta();
    int mx;
    for (int i = 0; i < 512; i++) sino[i] = ((i % P) == P / 2) ? 1 : 0;
    build_model();
    run_image(1'b0, 1'b0);
    mx = 0;
    total++; if (wr_val_q.size() != NPIX) begin bad++; $display("FAIL delta_count got=%0d want=%0d", wr_val_q.size(), NPIX); end
    for (int k = 0; k < wr_val_q.size() && k < NPIX; k++) begin
      if (wr_val_q[k] > mx) mx = wr_val_q[k];
      total++; if (wr_val_q[k] != exp_img[wr_addr_q[k] & 255]) begin bad++; $display("FAIL delta_val addr=%0d got=%0d want=%0d", wr_addr_q[k], wr_val_q[k], exp_img[wr_addr_q[k] & 255]); end
    end
    if (wr_val_q.size() == NPIX) begin
      total++; if (wr_val_q[8 * N + 8] != 16) begin bad++; $display("FAIL delta_centre got=%0d want=16", wr_val_q[8 * N + 8]); end
      total++; if (mx > 16) begin bad++; $display("FAIL delta_max got=%0d want<=16", mx); end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 512; i++) sino[i] = int'($urandom_range(0, 255));
    build_model();
    run_image(1'b1, 1'b0);
    total++; if (wr_addr_q.size() != NPIX) begin bad++; $display("FAIL stall_count got=%0d want=%0d", wr_addr_q.size(), NPIX); end
    for (int k = 0; k < wr_addr_q.size() && k < NPIX; k++) begin
      total++; if (wr_addr_q[k] != k || wr_val_q[k] != exp_img[k]) begin bad++; $display("FAIL stall_write idx=%0d got=%0d/%0d want=%0d/%0d", k, wr_addr_q[k], wr_val_q[k], k, exp_img[k]); end
    end
    total++; if (stall_err != 0) begin bad++; $display("FAIL stall_hold got=%0d want=0", stall_err); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 512; i++) sino[i] = int'($urandom_range(0, 255));
    build_model();
    @(posedge clk); #1; sg_kick = 1'b1; ir_enable = 1'b1;
    @(posedge clk); #1; sg_kick = 1'b0;
    repeat (30) @(posedge clk);
    #1; reset_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if ({ir_addr_valid, sg_done, ir_kick, ir_done} !== 4'b0000) begin bad++; $display("FAIL mid_reset_flags got=%b want=0000", {ir_addr_valid, sg_done, ir_kick, ir_done}); end
    total++; if ({sg_addr, ir_addr, ir_val} !== 29'd0) begin bad++; $display("FAIL mid_reset_busses got=%0h want=0", {sg_addr, ir_addr, ir_val}); end
    @(posedge clk); #1; reset_n = 1'b0;
    run_image(1'b0, 1'b0);
    total++; if (wr_addr_q.size() != NPIX || kick_n != 1) begin bad++; $display("FAIL mid_rerun count=%0d kicks=%0d want=%0d/1", wr_addr_q.size(), kick_n, NPIX); end
    for (int k = 0; k < wr_addr_q.size() && k < NPIX; k++) begin
      total++; if (wr_addr_q[k] != k || wr_val_q[k] != exp_img[k]) begin bad++; $display("FAIL mid_rerun_write idx=%0d got=%0d/%0d want=%0d/%0d", k, wr_addr_q[k], wr_val_q[k], k, exp_img[k]); end
    end
  endtask

  task automatic test_rekick();
    for (int i = 0; i < 512; i++) sino[i] = int'($urandom_range(0, 255));
    build_model();
    run_image(1'b0, 1'b1);
    total++; if (kick_n != 1) begin bad++; $display("FAIL rekick_ir_kick got=%0d want=1", kick_n); end
    total++; if (done_n != 1) begin bad++; $display("FAIL rekick_ir_done got=%0d want=1", done_n); end
    total++; if (sgd_n != 1)  begin bad++; $display("FAIL rekick_sg_done got=%0d want=1", sgd_n); end
    total++; if (wr_addr_q.size() != NPIX) begin bad++; $display("FAIL rekick_count got=%0d want=%0d", wr_addr_q.size(), NPIX); end
    for (int k = 0; k < wr_addr_q.size() && k < NPIX; k++) begin
      total++; if (wr_val_q[k] != exp_img[wr_addr_q[k] & 255]) begin bad++; $display("FAIL rekick_val addr=%0d got=%0d want=%0d", wr_addr_q[k], wr_val_q[k], exp_img[wr_addr_q[k] & 255]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) sino[i] = 0;
    test_reset();
    test_all_ones();
    test_delta();
    test_stall();
    test_reset_mid();
    test_rekick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
